// File: rtl/six_step_commutator.sv
// six_step_commutator: PWM carrier, six-step sector sequencer with align phase and
// complementary high/low-side gate drives.
// Optional feature macro: DEADTIME_EN (per-phase both-off gap of dead_time cycles
// on every change of a phase's desired state). Default build drives ls = ~hs.
module six_step_commutator #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DWELL_W       = 16,
    parameter int unsigned DEAD_W        = 8,
    parameter int unsigned ALIGN_PERIODS = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               dir,
    input  logic [CNT_W-1:0]   pwm_period,
    input  logic [CNT_W-1:0]   duty,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DEAD_W-1:0]  dead_time,
    output logic [2:0]         hs,
    output logic [2:0]         ls,
    output logic [2:0]         sector,
    output logic               sector_tick,
    output logic               pwm_tick,
    output logic               running
);

    localparam int unsigned ALIGN_W = (ALIGN_PERIODS > 1) ? $clog2(ALIGN_PERIODS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALIGN = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, period_s, duty_s;
    logic [DWELL_W-1:0] dwell_s, dwell_cnt;
    logic [ALIGN_W-1:0] align_cnt;
    logic [2:0]         sec;

    logic               idle, wrap, align_done, dwell_hit, pwm_on;
    logic [CNT_W-1:0]   period_clamp, period_eff, duty_eff;
    logic [DWELL_W-1:0] dwell_eff;
    logic [2:0]         sec_nxt, pat, d;

    // Carrier, shadow selection and pattern decode
    always_comb begin
        idle         = (state == S_IDLE);
        period_clamp = (pwm_period < CNT_W'(2)) ? CNT_W'(2) : pwm_period;
        // On the IDLE-exit edge the carrier is at position 0 and the inputs are being captured
        period_eff   = idle ? period_clamp : period_s;
        duty_eff     = idle ? duty : duty_s;
        wrap         = !idle && (cnt == period_eff - CNT_W'(1));
        align_done   = (align_cnt == ALIGN_W'(ALIGN_PERIODS - 1));
        dwell_eff    = (dwell_s == '0) ? DWELL_W'(1) : dwell_s;
        dwell_hit    = (dwell_cnt >= dwell_eff - DWELL_W'(1));
        pwm_on       = (cnt < duty_eff);
        if (dir) sec_nxt = (sec == 3'd0) ? 3'd5 : sec - 3'd1;
        else     sec_nxt = (sec == 3'd5) ? 3'd0 : sec + 3'd1;
        case (sec)
            3'd0:    pat = 3'b100;
            3'd1:    pat = 3'b110;
            3'd2:    pat = 3'b010;
            3'd3:    pat = 3'b011;
            3'd4:    pat = 3'b001;
            default: pat = 3'b101;
        endcase
        d = pat & {3{pwm_on}};
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = (ALIGN_PERIODS == 0) ? S_RUN : S_ALIGN;
                S_ALIGN: if (wrap && align_done) state_nxt = S_RUN;
                S_RUN:   state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Carrier counter, shadow registers, align/dwell counters and sector
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt       <= '0;
            period_s  <= '0;
            duty_s    <= '0;
            dwell_s   <= '0;
            dwell_cnt <= '0;
            align_cnt <= '0;
            sec       <= '0;
        end else if (idle) begin
            cnt      <= CNT_W'(1);
            period_s <= period_clamp;
            duty_s   <= duty;
            dwell_s  <= dwell;
        end else if (wrap) begin
            cnt      <= '0;
            period_s <= period_clamp;
            duty_s   <= duty;
            dwell_s  <= dwell;
            if (state == S_ALIGN)
                align_cnt <= align_done ? '0 : align_cnt + ALIGN_W'(1);
            if (state == S_RUN) begin
                if (dwell_hit) begin
                    dwell_cnt <= '0;
                    sec       <= sec_nxt;
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef DEADTIME_EN
    logic [2:0]        d_q;
    logic [DEAD_W-1:0] gap [3];

    // Registered outputs with per-phase dead-time insertion
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            hs          <= '0;
            ls          <= '0;
            sector      <= '0;
            sector_tick <= 1'b0;
            pwm_tick    <= 1'b0;
            running     <= 1'b0;
            d_q         <= '0;
            for (int i = 0; i < 3; i++) gap[i] <= '0;
        end else begin
            sector      <= sec;
            sector_tick <= (sec != sector);
            pwm_tick    <= wrap;
            running     <= 1'b1;
            d_q         <= d;
            for (int i = 0; i < 3; i++) begin
                if ((d[i] != d_q[i]) && (dead_time != '0)) begin
                    hs[i]  <= 1'b0;
                    ls[i]  <= 1'b0;
                    gap[i] <= dead_time - DEAD_W'(1);
                end else if (gap[i] != '0) begin
                    hs[i]  <= 1'b0;
                    ls[i]  <= 1'b0;
                    gap[i] <= gap[i] - DEAD_W'(1);
                end else begin
                    hs[i]  <= d[i];
                    ls[i]  <= ~d[i];
                end
            end
        end
    end
`else
    logic unused_dead_time;
    assign unused_dead_time = ^dead_time;

    // Registered outputs, complementary drive without gap
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            hs          <= '0;
            ls          <= '0;
            sector      <= '0;
            sector_tick <= 1'b0;
            pwm_tick    <= 1'b0;
            running     <= 1'b0;
        end else begin
            hs          <= d;
            ls          <= ~d;
            sector      <= sec;
            sector_tick <= (sec != sector);
            pwm_tick    <= wrap;
            running     <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_six_step_commutator.sv
// Scoreboard bench for six_step_commutator: two instances (no align phase, 100-period
// align phase) share stimulus; a timeline model predicts each output cycle.
module tb_six_step_commutator;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned DEAD_W  = 8;

    typedef struct packed {
        logic [2:0] hs;
        logic [2:0] ls;
        logic [2:0] sector;
        logic       sector_tick;
        logic       pwm_tick;
        logic       running;
    } obs_t;

    // Model state: position in the current carrier period and settings latched per period
    typedef struct {
        bit on;
        bit run;
        int pos;
        int p;
        int duty;
        int dwell;
        int np;
        int nduty;
        int ndwell;
        int ad;
        int dd;
        int sec;
        int nsec;
        int shown;
    } ms_t;

    logic               clk;
    logic               rst, enable, dir;
    logic [CNT_W-1:0]   pwm_period, duty;
    logic [DWELL_W-1:0] dwell;
    logic [DEAD_W-1:0]  dead_time;

    logic [2:0] hs0, ls0, sec0, hs1, ls1, sec1;
    logic       st0, pt0, run0, st1, pt1, run1;

    obs_t q0[$];
    obs_t q1[$];
    ms_t  m0, m1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ticks0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    six_step_commutator #(.CNT_W(CNT_W), .DWELL_W(DWELL_W), .DEAD_W(DEAD_W), .ALIGN_PERIODS(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .pwm_period(pwm_period), .duty(duty),
        .dwell(dwell), .dead_time(dead_time), .hs(hs0), .ls(ls0), .sector(sec0),
        .sector_tick(st0), .pwm_tick(pt0), .running(run0));

    six_step_commutator #(.CNT_W(CNT_W), .DWELL_W(DWELL_W), .DEAD_W(DEAD_W), .ALIGN_PERIODS(100)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .pwm_period(pwm_period), .duty(duty),
        .dwell(dwell), .dead_time(dead_time), .hs(hs1), .ls(ls1), .sector(sec1),
        .sector_tick(st1), .pwm_tick(pt1), .running(run1));

    function automatic logic [2:0] pat_of(input int s);
        logic [2:0] t;
        case (s)
            0:       t = 3'b100;
            1:       t = 3'b110;
            2:       t = 3'b010;
            3:       t = 3'b011;
            4:       t = 3'b001;
            default: t = 3'b101;
        endcase
        return t;
    endfunction

    function automatic int at_least(input int x, input int lo);
        return (x < lo) ? lo : x;
    endfunction

    // Predict the outputs that appear after one clock edge given the inputs seen at that edge
    function automatic void step(input int aper, inout ms_t s, input logic r, input logic en,
                                 input logic dr, input int per, input int du, input int dw,
                                 output obs_t o);
        bit on;
        o = '0;
        if (r || !en) begin
            s.on = 0;
            return;
        end
        if (!s.on) begin
            s.on = 1; s.run = (aper == 0); s.pos = 0;
            s.p = at_least(per, 2); s.duty = du; s.dwell = dw;
            s.ad = 0; s.dd = 0; s.sec = 0; s.shown = 0;
        end else if (s.pos == s.p - 1) begin
            s.pos = 0; s.p = s.np; s.duty = s.nduty; s.dwell = s.ndwell; s.sec = s.nsec;
        end else begin
            s.pos++;
        end
        on            = (s.pos < s.duty);
        o.running     = 1'b1;
        o.sector      = 3'(s.sec);
        o.sector_tick = (s.sec != s.shown);
        s.shown       = s.sec;
        o.hs          = pat_of(s.sec) & {3{on}};
        o.ls          = ~o.hs;
        o.pwm_tick    = (s.pos == s.p - 1);
        if (o.pwm_tick) begin
            s.np = at_least(per, 2); s.nduty = du; s.ndwell = dw; s.nsec = s.sec;
            if (s.run) begin
                s.dd++;
                if (s.dd >= at_least(s.dwell, 1)) begin
                    s.dd   = 0;
                    s.nsec = dr ? (s.sec + 5) % 6 : (s.sec + 1) % 6;
                end
            end else begin
                s.ad++;
                if (s.ad >= aper) begin
                    s.run = 1;
                    s.dd  = 0;
                end
            end
        end
    endfunction

    task automatic compare(input string nm, input obs_t a, input obs_t x);
        bit bad;
        checks++;
`ifdef DEADTIME_EN
        bad = ({a.sector, a.sector_tick, a.pwm_tick, a.running} !=
               {x.sector, x.sector_tick, x.pwm_tick, x.running});
`else
        bad = (a != x);
`endif
        if (bad) begin
            errors++;
            $display("FAIL %s cyc=%0d got hs=%b ls=%b sec=%0d stick=%b ptick=%b run=%b want hs=%b ls=%b sec=%0d stick=%b ptick=%b run=%b",
                     nm, cyc, a.hs, a.ls, a.sector, a.sector_tick, a.pwm_tick, a.running,
                     x.hs, x.ls, x.sector, x.sector_tick, x.pwm_tick, x.running);
        end
        checks++;
        if (((a.hs & a.ls) != 3'b000) || (a.sector > 3'd5)) begin
            errors++;
            $display("FAIL %s_invariant cyc=%0d got hs=%b ls=%b sector=%0d want no hs&ls overlap and sector<=5",
                     nm, cyc, a.hs, a.ls, a.sector);
        end
    endtask

    // Reference model: one expected entry per instance per clock edge
    always @(posedge clk) begin
        obs_t e;
        step(0, m0, rst, enable, dir, int'(pwm_period), int'(duty), int'(dwell), e);
        q0.push_back(e);
        step(100, m1, rst, enable, dir, int'(pwm_period), int'(duty), int'(dwell), e);
        q1.push_back(e);
    end

    // Monitor: pop expectations and compare away from the active edge
    always @(negedge clk) begin
        obs_t a;
        obs_t x;
        cyc++;
        a = {hs0, ls0, sec0, st0, pt0, run0};
        if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut0_queue cyc=%0d got empty want an expected entry", cyc);
        end else begin
            x = q0.pop_front();
            compare("dut0", a, x);
        end
        if (st0) ticks0++;
        a = {hs1, ls1, sec1, st1, pt1, run1};
        if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_queue cyc=%0d got empty want an expected entry", cyc);
        end else begin
            x = q1.pop_front();
            compare("dut1", a, x);
        end
    end

    // Stimulus: directed scenarios then randomized settings
    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};
        rst = 1'b1; enable = 1'b1; dir = 1'b0;
        pwm_period = CNT_W'(10); duty = CNT_W'(5); dwell = DWELL_W'(10); dead_time = DEAD_W'(3);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (650) @(negedge clk);
        dir = 1'b1;
        repeat (230) @(negedge clk);
        dir = 1'b0;
        repeat (30) @(negedge clk);
        dir = 1'b1;
        repeat (400) @(negedge clk);
        duty = CNT_W'(0);
        repeat (60) @(negedge clk);
        duty = CNT_W'(12);
        repeat (60) @(negedge clk);
        pwm_period = CNT_W'(1); duty = CNT_W'(1);
        repeat (60) @(negedge clk);
        pwm_period = CNT_W'(10); duty = CNT_W'(5);
        repeat (37) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (1200) @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            pwm_period = CNT_W'($urandom_range(0, 12));
            duty       = CNT_W'($urandom_range(0, 14));
            dwell      = DWELL_W'($urandom_range(0, 3));
            dir        = 1'($urandom_range(0, 1));
            enable     = ($urandom_range(0, 99) != 0);
            rst        = ($urandom_range(0, 149) == 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            enable = 1'b1;
            rst    = 1'b0;
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ((q0.size() != 0) || (q1.size() != 0)) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d entries want 0/0", q0.size(), q1.size());
        end
        checks++;
        if (ticks0 < 6) begin
            errors++;
            $display("FAIL sector_tick_count got %0d want >= 6", ticks0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
